// File: rtl/pipe_hazard_controller.sv
// Pipeline hazard controller for a five-stage in-order pipeline.
// Generates the pipe-register load enables and synchronous flushes for
// memory wait-states, taken branches and load-use hazards. It also keeps
// saturating counters of stall cycles and branch-flush cycles.
module pipe_hazard_controller (
    input  logic        clock,
    input  logic        sync_reset,
    input  logic [4:0]  rs1_D,
    input  logic [4:0]  rs2_D,
    input  logic [4:0]  rd_E,
    input  logic        mem_read_E,
    input  logic        pc_src_E,
    input  logic        mem_req_M,
    input  logic        mem_ready,
    output logic        enabler_F,
    output logic        enabler_D,
    output logic        enabler_E,
    output logic        enabler_M,
    output logic        flush_D,
    output logic        flush_E,
    output logic        flush_W,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    state_t      state_q, state_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic mem_stall;
    logic release_cyc;
    logic load_use;
    logic branch_flush;

    // Hazard detection. A wait that starts in RUN stalls immediately,
    // and MEM_WAIT keeps stalling until the ready cycle.
    always_comb begin
        release_cyc  = (state_q == MEM_WAIT) && mem_ready;
        mem_stall    = (state_q == MEM_WAIT) ? !mem_ready
                                             : (mem_req_M && !mem_ready);
        load_use     = mem_read_E && (rd_E != 5'd0) &&
                       ((rd_E == rs1_D) || (rd_E == rs2_D));
        branch_flush = !sync_reset && !mem_stall && pc_src_E;
    end

    // Next-state logic for the memory wait FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (mem_req_M && !mem_ready) state_d = MEM_WAIT;
            MEM_WAIT: if (mem_ready)               state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // Control outputs, in priority order: reset, memory stall, branch,
    // load-use. The release cycle lets everything advance. A branch held in
    // Execute across the wait therefore flushes on that cycle.
    always_comb begin
        enabler_F = 1'b1;
        enabler_D = 1'b1;
        enabler_E = 1'b1;
        enabler_M = 1'b1;
        flush_D   = 1'b0;
        flush_E   = 1'b0;
        flush_W   = 1'b0;
        if (sync_reset) begin
            enabler_F = 1'b0;
            enabler_D = 1'b0;
            enabler_E = 1'b0;
            enabler_M = 1'b0;
            flush_D   = 1'b1;
            flush_E   = 1'b1;
            flush_W   = 1'b1;
        end else if (mem_stall) begin
            enabler_F = 1'b0;
            enabler_D = 1'b0;
            enabler_E = 1'b0;
            enabler_M = 1'b0;
            flush_W   = 1'b1;
        end else if (pc_src_E) begin
            flush_D   = 1'b1;
            flush_E   = 1'b1;
        end else if (load_use && !release_cyc) begin
            enabler_F = 1'b0;
            enabler_D = 1'b0;
            flush_E   = 1'b1;
        end
    end

    // Saturating event counters. Cycles spent in reset are not counted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (sync_reset) begin
            stall_cnt_d = 16'd0;
            flush_cnt_d = 16'd0;
        end else begin
            if (!enabler_F && (stall_cnt_q != CNT_MAX))
                stall_cnt_d = stall_cnt_q + 16'd1;
            if (branch_flush && (flush_cnt_q != CNT_MAX))
                flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    // State and counter registers. Reset is synchronous.
    always_ff @(posedge clock) begin
        if (sync_reset) begin
            state_q     <= RUN;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_controller.sv
// Self-checking bench for pipe_hazard_controller.
// It runs directed scenarios, then random traffic, then a counter saturation
// run. Every result is checked against a behavioural model of the rules.
module tb_pipe_hazard_controller;

    logic        clock = 1'b0;
    logic        sync_reset;
    logic [4:0]  rs1_D, rs2_D, rd_E;
    logic        mem_read_E, pc_src_E, mem_req_M, mem_ready;
    logic        enabler_F, enabler_D, enabler_E, enabler_M;
    logic        flush_D, flush_E, flush_W;
    logic [15:0] stall_cycles, flush_events;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model state.
    bit m_waiting;
    int m_stall;
    int m_flush;

    always #5 clock = ~clock;

    pipe_hazard_controller dut (
        .clock        (clock),
        .sync_reset   (sync_reset),
        .rs1_D        (rs1_D),
        .rs2_D        (rs2_D),
        .rd_E         (rd_E),
        .mem_read_E   (mem_read_E),
        .pc_src_E     (pc_src_E),
        .mem_req_M    (mem_req_M),
        .mem_ready    (mem_ready),
        .enabler_F    (enabler_F),
        .enabler_D    (enabler_D),
        .enabler_E    (enabler_E),
        .enabler_M    (enabler_M),
        .flush_D      (flush_D),
        .flush_E      (flush_E),
        .flush_W      (flush_W),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    // Expected {enF,enD,enE,enM,flD,flE,flW} for the current inputs.
    function automatic logic [6:0] model_ctrl();
        bit waiting_now;
        bit hazard;
        waiting_now = m_waiting ? !mem_ready : (mem_req_M && !mem_ready);
        hazard = mem_read_E && (rd_E != 0) && ((rd_E == rs1_D) || (rd_E == rs2_D));
        if (sync_reset)                    return 7'b0000_111;
        if (waiting_now)                   return 7'b0000_001;
        if (pc_src_E)                      return 7'b1111_110;
        if (hazard && !(m_waiting && mem_ready)) return 7'b0011_010;
        return 7'b1111_000;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check the outputs at the falling edge, then step the model at the edge.
    task automatic cycle(input string tag, input bit check);
        logic [6:0] e;
        logic [6:0] o;
        #4;
        e = model_ctrl();
        o = {enabler_F, enabler_D, enabler_E, enabler_M, flush_D, flush_E, flush_W};
        if (check) begin
            chk({tag, "_ctrl"}, {9'd0, o}, {9'd0, e});
            chk({tag, "_stall"}, stall_cycles, m_stall[15:0]);
            chk({tag, "_flush"}, flush_events, m_flush[15:0]);
            $display("[%0t] %s rst=%0b req=%0b rdy=%0b pc=%0b ld=%0b rd=%0d rs=%0d/%0d ctrl=%b cnt=%0d/%0d",
                     $time, tag, sync_reset, mem_req_M, mem_ready, pc_src_E, mem_read_E,
                     rd_E, rs1_D, rs2_D, o, stall_cycles, flush_events);
        end
        @(posedge clock);
        if (sync_reset) begin
            m_waiting = 1'b0;
            m_stall   = 0;
            m_flush   = 0;
        end else begin
            if (!e[6] && m_stall < 65535) m_stall++;
            if (e[2] && m_flush < 65535) m_flush++;
            m_waiting = m_waiting ? !mem_ready : (mem_req_M && !mem_ready);
        end
        #1;
    endtask

    task automatic idle_inputs();
        sync_reset = 1'b0;
        rs1_D = 5'd1; rs2_D = 5'd2; rd_E = 5'd3;
        mem_read_E = 1'b0; pc_src_E = 1'b0;
        mem_req_M = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        sync_reset = 1'b1;
        cycle("reset", 1'b1);
        sync_reset = 1'b0;
    endtask

    initial begin
        m_waiting = 1'b0; m_stall = 0; m_flush = 0;
        idle_inputs();
        sync_reset = 1'b1;
        @(posedge clock); #1;
        cycle("reset0", 1'b1);
        cycle("reset1", 1'b1);
        sync_reset = 1'b0;
        chk("reset_stall_zero", stall_cycles, 16'd0);
        chk("reset_flush_zero", flush_events, 16'd0);
        cycle("idle", 1'b1);

        // Load-use on rs2
        mem_read_E = 1'b1; rd_E = 5'd5; rs2_D = 5'd5; rs1_D = 5'd9;
        cycle("loaduse", 1'b1);
        chk("loaduse_stall_count", stall_cycles, 16'd1);
        // Load to x0 never stalls
        rd_E = 5'd0; rs1_D = 5'd0; rs2_D = 5'd4;
        cycle("loaduse_x0", 1'b1);
        chk("x0_enabler_F", {15'd0, enabler_F}, 16'd1);
        idle_inputs();

        // Three memory wait cycles, then ready
        do_reset();
        mem_req_M = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle("memwait", 1'b1);
        mem_ready = 1'b1;
        cycle("memrelease", 1'b1);
        chk("memwait_stall_count", stall_cycles, 16'd3);
        mem_req_M = 1'b0; mem_ready = 1'b0;
        cycle("after_release_run", 1'b1);
        idle_inputs();

        // Branch and load-use in the same cycle
        do_reset();
        pc_src_E = 1'b1; mem_read_E = 1'b1; rd_E = 5'd7; rs1_D = 5'd7;
        cycle("branch_loaduse", 1'b1);
        chk("branch_flush_count", flush_events, 16'd1);
        idle_inputs();

        // Branch held across a memory wait
        do_reset();
        pc_src_E = 1'b1; mem_req_M = 1'b1; mem_ready = 1'b0;
        cycle("branch_wait0", 1'b1);
        cycle("branch_wait1", 1'b1);
        chk("branch_wait_no_flush", flush_events, 16'd0);
        mem_ready = 1'b1;
        cycle("branch_release", 1'b1);
        chk("branch_release_flush", flush_events, 16'd1);
        idle_inputs();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            sync_reset = ($urandom_range(0, 63) == 0);
            mem_req_M  = 1'($urandom_range(0, 1));
            mem_ready  = ($urandom_range(0, 3) != 0);
            pc_src_E   = ($urandom_range(0, 4) == 0);
            mem_read_E = 1'($urandom_range(0, 1));
            rd_E       = 5'($urandom_range(0, 3));
            rs1_D      = 5'($urandom_range(0, 3));
            rs2_D      = 5'($urandom_range(0, 3));
            cycle("rand", 1'b1);
        end
        idle_inputs();

        // Stall counter saturation, then reset while in MEM_WAIT
        do_reset();
        mem_req_M = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 65537; i++) cycle("sat", 1'b0);
        chk("sat_stall_count", stall_cycles, 16'hFFFF);
        cycle("sat_hold", 1'b1);
        sync_reset = 1'b1;
        cycle("reset_in_wait", 1'b1);
        sync_reset = 1'b0; mem_req_M = 1'b0; mem_ready = 1'b0;
        cycle("post_reset_run", 1'b1);
        chk("post_reset_stall", stall_cycles, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_controller.md
PIPE_HAZARD_CONTROLLER -- requirements
Module: pipe_hazard_controller

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 sync_reset  input  1  synchronous active-high reset.
REQ-004 rs1_D  input  5  source register 1 of the instruction in Decode.
REQ-005 rs2_D  input  5  source register 2 of the instruction in Decode.
REQ-006 rd_E  input  5  destination register of the instruction in Execute.
REQ-007 mem_read_E  input  1  the instruction in Execute is a load.
REQ-008 pc_src_E  input  1  a taken branch or jump resolved in Execute.
REQ-009 mem_req_M  input  1  the instruction in Memory accesses data memory.
REQ-010 mem_ready  input  1  data memory completes the access this cycle.
REQ-011 enabler_F, enabler_D, enabler_E, enabler_M  output  1 each  pipeline-register load enables.
REQ-012 flush_D, flush_E, flush_W  output  1 each  synchronous clear of the Decode, Execute and Writeback pipe registers.
REQ-013 stall_cycles  output  16  saturating count of cycles with enabler_F=0 outside reset.
REQ-014 flush_events  output  16  saturating count of branch-flush cycles.

Function
REQ-015 FSM states SHALL be RUN and MEM_WAIT, held in a register.
REQ-016 Control outputs SHALL be combinational from state and inputs; counters and state SHALL be registered.
REQ-017 RUN->MEM_WAIT SHALL occur when mem_req_M=1 and mem_ready=0; MEM_WAIT->RUN SHALL occur on the first cycle mem_ready=1.
REQ-018 Memory stall SHALL apply in MEM_WAIT, and in RUN when mem_req_M=1 and mem_ready=0: all four enablers=0, flush_D=flush_E=0, flush_W=1.
REQ-019 On the release cycle (MEM_WAIT with mem_ready=1), all enablers SHALL be 1 and flush_W=0.
REQ-020 mem_req_M=1 with mem_ready=1 in RUN SHALL cause no stall.
REQ-021 Load-use hazard SHALL be mem_read_E=1, rd_E!=0, and rd_E equal to rs1_D or rs2_D.
REQ-022 On a load-use hazard: enabler_F=enabler_D=0, flush_E=1, enabler_E=enabler_M=1, and the other flushes=0.
REQ-023 On pc_src_E=1: flush_D=flush_E=1, all enablers=1, flush_W=0.
REQ-024 Priority SHALL be memory stall > branch flush > load-use; a branch deferred by a memory stall SHALL take effect on the release cycle, because the Execute register holds pc_src_E.
REQ-025 With no event, all enablers SHALL be 1 and all flushes 0.
REQ-026 stall_cycles SHALL increment by 1 on each cycle with enabler_F=0 and sync_reset=0, saturating at 16'hFFFF.
REQ-027 flush_events SHALL increment on each cycle where the branch flush of REQ-023 is applied, saturating at 16'hFFFF.
REQ-028 rd_E=0 SHALL never produce a load-use stall.

Reset
REQ-029 While sync_reset=1: state<=RUN, and both counters<=0 at the clock edge.
REQ-030 While sync_reset=1: enablers=0 and flush_D=flush_E=flush_W=1, regardless of other inputs.
REQ-031 Reset asserted in MEM_WAIT SHALL return to RUN on the next edge, with no pending-stall memory.

Verification
REQ-032 Load-use: mem_read_E=1, rd_E=5, rs2_D=5 for one cycle -> enabler_F=enabler_D=0, flush_E=1, stall_cycles 0->1.
REQ-033 Variant: rd_E=0, rs1_D=0 with mem_read_E=1 -> no stall, all enablers 1.
REQ-034 Memory wait: mem_req_M=1, mem_ready=0 for 3 cycles then 1 -> 3 cycles with all enablers 0 and flush_W=1, back in RUN after the ready cycle, stall_cycles=3.
REQ-035 Branch + load-use same cycle (pc_src_E=1, mem_read_E=1, rd_E=rs1_D=7) -> flush_D=flush_E=1, enablers 1, flush_events=1.
REQ-036 Branch during memory wait: pc_src_E=1 held through 2 wait cycles -> no flush during the wait; flush_D=flush_E=1 on the release cycle only.
REQ-037 Saturation: force 65537 stall cycles -> stall_cycles=16'hFFFF. Then pulse sync_reset in MEM_WAIT -> state RUN, counters 0, flushes 1 during reset.
